input_buffer_onoff: RTL and testbench

- Per-input-port flit FIFO, sitting at the receiving end of a router link.
- Generates the per-port on/off flow-control bit that the upstream switch allocator consumes as on_off_i[port].
- Stores incoming flits and presents the head flit to the local routing and switch allocation logic.
- Asserts on/off with hysteresis thresholds sized to absorb flits still in flight after OFF is raised.

---
 rtl/input_buffer_onoff_pkg.sv | 9 +
 rtl/input_buffer_onoff_circular_fifo.sv | 44 ++++
 rtl/input_buffer_onoff.sv | 77 +++++++
 tb/tb_input_buffer_onoff.sv | 124 ++++++++++++
 4 files changed

// File: rtl/input_buffer_onoff_pkg.sv
// noc_params: shared NoC widths, buffer sizing defaults, flit type and on/off state encoding
package noc_params;
  localparam int FLIT_WIDTH = 32;
  localparam int BUFFER_SIZE = 8;
  localparam int OFF_THRESHOLD = 5;
  localparam int ON_THRESHOLD = 2;
  typedef logic [FLIT_WIDTH-1:0] flit_t;
  typedef enum logic {ON = 1'b0, OFF = 1'b1} onoff_state_t;
endpackage

// File: rtl/input_buffer_onoff_circular_fifo.sv
// circular_fifo: show-ahead circular flit buffer with occupancy count
// Ports: clk, rst (async active-low), data_i/valid_i write side, read_i pop,
//        data_o head flit, empty_o, count_o occupancy, next_count_o occupancy after this edge.
module circular_fifo
  import noc_params::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     valid_i,
  input  logic                     read_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   next_count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic rd_ok, wr_ok;
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign rd_ok = read_i && count != '0;
  assign wr_ok = valid_i && (count != (AW+1)'(DEPTH) || rd_ok);
  assign next_count_o = count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  assign data_o = mem[rd_ptr];
  assign empty_o = count == '0;
  assign count_o = count;
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= data_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(rd_ok);
      wr_ptr <= wr_ptr + AW'(wr_ok);
      count <= next_count_o;
    end
endmodule

// File: rtl/input_buffer_onoff.sv
// input_buffer_onoff: router input-port flit FIFO with hysteresis on/off flow control
// Ports: clk, rst (async active-low), data_i/valid_i from upstream link, read_i from
//        switch-allocation grant, data_o head flit, empty_o, count_o, on_off_o (1 = may send).
// Optional: define INPUT_BUFFER_ERR_CHECK_EN to add sticky overflow_o/underflow_o.
module input_buffer_onoff
  import noc_params::*;
#(
  parameter int FLIT_WIDTH = noc_params::FLIT_WIDTH,
  parameter int BUFFER_SIZE = noc_params::BUFFER_SIZE,
  parameter int OFF_THRESHOLD = noc_params::OFF_THRESHOLD,
  parameter int ON_THRESHOLD = noc_params::ON_THRESHOLD
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FLIT_WIDTH-1:0]          data_i,
  input  logic                           valid_i,
  input  logic                           read_i,
  output logic [FLIT_WIDTH-1:0]          data_o,
  output logic                           empty_o,
  output logic [$clog2(BUFFER_SIZE):0]   count_o,
  output logic                           on_off_o
`ifdef INPUT_BUFFER_ERR_CHECK_EN
  ,
  output logic                           overflow_o,
  output logic                           underflow_o
`endif
);
  localparam int CW = $clog2(BUFFER_SIZE) + 1;
  // OFF must leave room for the flits already committed upstream when OFF is raised
  if (BUFFER_SIZE < 4 || (BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0) begin : g_bad_size
    $error("BUFFER_SIZE must be a power of 2 and at least 4");
  end
  if (BUFFER_SIZE - OFF_THRESHOLD < 3) begin : g_bad_slack
    $error("BUFFER_SIZE - OFF_THRESHOLD must be at least 3");
  end
  if (OFF_THRESHOLD <= ON_THRESHOLD) begin : g_bad_hyst
    $error("OFF_THRESHOLD must exceed ON_THRESHOLD");
  end
  logic [CW-1:0] next_count;
  onoff_state_t state;
  circular_fifo #(.WIDTH(FLIT_WIDTH), .DEPTH(BUFFER_SIZE)) u_fifo (
    .clk(clk),
    .rst(rst),
    .data_i(data_i),
    .valid_i(valid_i),
    .read_i(read_i),
    .data_o(data_o),
    .empty_o(empty_o),
    .count_o(count_o),
    .next_count_o(next_count)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ON;
    else state <= (state == ON && next_count >= CW'(OFF_THRESHOLD)) ? OFF :
                  (state == OFF && next_count <= CW'(ON_THRESHOLD)) ? ON : state;
  assign on_off_o = state == ON;
`ifdef INPUT_BUFFER_ERR_CHECK_EN
  logic drop, bad_read;
  assign drop = valid_i && count_o == CW'(BUFFER_SIZE) && !read_i;
  assign bad_read = read_i && empty_o;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      overflow_o <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o <= overflow_o | drop;
      underflow_o <= underflow_o | bad_read;
    end
`ifndef SYNTHESIS
  always @(posedge clk)
    if (rst) begin
      assert (!drop) else $warning("input_buffer_onoff: flit dropped while full");
      assert (!bad_read) else $warning("input_buffer_onoff: read while empty");
    end
`endif
`endif
endmodule

// File: tb/tb_input_buffer_onoff.sv
// tb_input_buffer_onoff: directed self-checking bench for input_buffer_onoff
module tb_input_buffer_onoff;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] data_i = '0;
  logic valid_i = 1'b0;
  logic read_i = 1'b0;
  logic [31:0] data_o;
  logic empty_o;
  logic [3:0] count_o;
  logic on_off_o;
`ifdef INPUT_BUFFER_ERR_CHECK_EN
  logic overflow_o, underflow_o;
`endif
  int total = 0;
  int bad = 0;
  input_buffer_onoff dut (
    .clk(clk),
    .rst(rst),
    .data_i(data_i),
    .valid_i(valid_i),
    .read_i(read_i),
    .data_o(data_o),
    .empty_o(empty_o),
    .count_o(count_o),
    .on_off_o(on_off_o)
`ifdef INPUT_BUFFER_ERR_CHECK_EN
    ,
    .overflow_o(overflow_o),
    .underflow_o(underflow_o)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] d, input logic r);
    valid_i = v;
    data_i = d;
    read_i = r;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    read_i = 1'b0;
  endtask
  initial begin
    logic [31:0] last;
    #12 rst = 1'b1;
    repeat (5) step(1'b0, '0, 1'b0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_onoff", 32'(on_off_o), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'hA0 + i, 1'b0);
      chk("fill_count", 32'(count_o), i + 1);
      chk("fill_head", data_o, 32'hA0);
      chk("fill_onoff", 32'(on_off_o), i < 4 ? 1 : 0);
    end
    for (int i = 5; i < 8; i++) step(1'b1, 32'hA0 + i, 1'b0);
    chk("full_count", 32'(count_o), 8);
    chk("full_onoff", 32'(on_off_o), 0);
    step(1'b1, 32'hFF, 1'b0);
    chk("drop_count", 32'(count_o), 8);
    chk("drop_head", data_o, 32'hA0);
`ifdef INPUT_BUFFER_ERR_CHECK_EN
    chk("overflow_set", 32'(overflow_o), 1);
    step(1'b0, '0, 1'b0);
    chk("overflow_sticky", 32'(overflow_o), 1);
`endif
    step(1'b1, 32'hB0, 1'b1);
    chk("full_rw_count", 32'(count_o), 8);
    chk("full_rw_head", data_o, 32'hA1);
    for (int i = 0; i < 6; i++) begin
      chk("drain_head", data_o, 32'hA1 + i);
      step(1'b0, '0, 1'b1);
      chk("drain_count", 32'(count_o), 7 - i);
      chk("drain_onoff", 32'(on_off_o), i == 5 ? 1 : 0);
    end
    chk("drain_head7", data_o, 32'hA7);
    step(1'b0, '0, 1'b1);
    chk("drain_headB0", data_o, 32'hB0);
    step(1'b0, '0, 1'b1);
    chk("drained_empty", 32'(empty_o), 1);
    step(1'b0, '0, 1'b1);
    chk("empty_read_count", 32'(count_o), 0);
    chk("empty_read_empty", 32'(empty_o), 1);
`ifdef INPUT_BUFFER_ERR_CHECK_EN
    chk("underflow_set", 32'(underflow_o), 1);
`endif
    // read at empty is not accepted, so only the write lands
    step(1'b1, 32'hC0, 1'b1);
    chk("empty_rw_count", 32'(count_o), 1);
    chk("empty_rw_head", data_o, 32'hC0);
    last = 32'hC0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 32'hC0 + i, 1'b1);
      chk("stream_count", 32'(count_o), 1);
      chk("stream_head", data_o, 32'hC0 + i);
      last = 32'hC0 + i;
    end
    for (int i = 0; i < 5; i++) step(1'b1, 32'hE0 + i, 1'b0);
    chk("pre_rst_count", 32'(count_o), 6);
    chk("pre_rst_onoff", 32'(on_off_o), 0);
    chk("pre_rst_head", data_o, last);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count_o), 0);
    chk("async_rst_empty", 32'(empty_o), 1);
    chk("async_rst_onoff", 32'(on_off_o), 1);
`ifdef INPUT_BUFFER_ERR_CHECK_EN
    chk("async_rst_ovf", 32'(overflow_o), 0);
`endif
    #1 rst = 1'b1;
    step(1'b1, 32'hD0, 1'b0);
    chk("post_rst_head", data_o, 32'hD0);
    chk("post_rst_count", 32'(count_o), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
